if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline (exception/interrupt variant); sits directly upstream of id_stage.
- Owns the architectural fetch PC and drives the synchronous-read instruction ROM.
- Hands {pc4, pc} to ID over if_to_id_bus using the valid/allow_in handshake.
- Takes branch redirects from EX and trap/mret redirects from the CSR unit, and flags misaligned fetch targets.

---
 rtl/if_stage.sv | 89 ++++++++
 tb/tb_if_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the synchronous-read
// instruction ROM and offers {pc4, pc} to ID over a valid/allow_in handshake.
// Branch (EX) and trap/mret (CSR) redirects override the sequential PC.
module if_stage #(
  parameter logic [31:0] RESET_PC           = 32'h0000_0000,
  parameter int unsigned IF_TO_ID_BUS_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_allow_in,
  input  logic                          br_taken,
  input  logic [31:0]                   br_target,
  input  logic                          trap_redirect,
  input  logic [31:0]                   trap_target,
  output logic [IF_TO_ID_BUS_WIDTH-1:0] if_to_id_bus,
  output logic                          if_to_id_valid,
  output logic                          if_excp,
  output logic [31:0]                   irom_addr,
  output logic                          irom_en
);

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fs_state_t;

  fs_state_t       fs_state;
  logic [PC_W-1:0] fs_pc;
  logic            fs_valid;

  logic            redirect;
  logic [PC_W-1:0] next_target;
  logic [PC_W-1:0] pc4;
  logic            fire;

  // Redirect selection (trap beats branch), handshake and ROM/ID-facing outputs
  always_comb begin
    redirect       = trap_redirect | br_taken;
    next_target    = trap_redirect ? trap_target : br_target;
    pc4            = fs_pc + PC_STEP;
    if_to_id_valid = 1'b0;
    irom_en        = 1'b0;
    if (fs_state == RUN) begin
      // the instruction at fs_pc is wrong-path whenever a redirect is active
      if_to_id_valid = fs_valid & ~redirect;
      irom_en        = fs_valid & ~redirect & id_allow_in;
    end
    fire         = if_to_id_valid & id_allow_in;
    if_excp      = fs_valid & (fs_pc[1:0] != 2'b00);
    irom_addr    = fs_pc;
    if_to_id_bus = IF_TO_ID_BUS_WIDTH'({pc4, fs_pc});
  end

  // Fetch PC / valid / boot-run sequencing; redirect never waits on a stalled ID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_state <= BOOT;
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC;
    end else begin
      case (fs_state)
        BOOT: begin
          fs_state <= RUN;
          fs_valid <= 1'b1;
          if (redirect) begin
            fs_pc <= next_target;
          end
        end
        RUN: begin
          if (redirect) begin
            fs_pc    <= next_target;
            fs_valid <= 1'b1;
          end else if (fire) begin
            fs_pc <= pc4;
          end
        end
        default: begin
          fs_state <= BOOT;
          fs_valid <= 1'b0;
          fs_pc    <= RESET_PC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected fetch PCs are queued as stimulus is
// driven and popped whenever the DUT completes an offer to ID.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        id_allow_in;
  logic        br_taken;
  logic [31:0] br_target;
  logic        trap_redirect;
  logic [31:0] trap_target;
  logic [63:0] if_to_id_bus;
  logic        if_to_id_valid;
  logic        if_excp;
  logic [31:0] irom_addr;
  logic        irom_en;

  int          n_tests = 0;
  int          n_fails = 0;
  logic [31:0] exp_q[$];

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .IF_TO_ID_BUS_WIDTH(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_allow_in(id_allow_in),
    .br_taken(br_taken),
    .br_target(br_target),
    .trap_redirect(trap_redirect),
    .trap_target(trap_target),
    .if_to_id_bus(if_to_id_bus),
    .if_to_id_valid(if_to_id_valid),
    .if_excp(if_excp),
    .irom_addr(irom_addr),
    .irom_en(irom_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every completed offer must match the oldest expected PC
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && if_to_id_valid && id_allow_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_offer", {32'd0, irom_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("offer_bus", if_to_id_bus, {e + 32'd4, e});
        chk("offer_excp", {63'd0, if_excp}, {63'd0, (e[1:0] != 2'b00)});
        chk("offer_irom_addr", {32'd0, irom_addr}, {32'd0, e});
        chk("offer_irom_en", {63'd0, irom_en}, 64'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_allow_in = 1'b1;
    br_taken = 1'b0; br_target = 32'd0;
    trap_redirect = 1'b0; trap_target = 32'd0;
    #3;
    // reset state
    chk("rst_valid", {63'd0, if_to_id_valid}, 64'd0);
    chk("rst_irom_en", {63'd0, irom_en}, 64'd0);
    chk("rst_excp", {63'd0, if_excp}, 64'd0);
    chk("rst_bus", if_to_id_bus, {32'd4, 32'd0});

    // release reset: one BOOT cycle, then sequential fetch 0,4,8,C
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("boot_valid", {63'd0, if_to_id_valid}, 64'd0);
    chk("boot_irom_en", {63'd0, irom_en}, 64'd0);
    exp_q.push_back(32'h00); exp_q.push_back(32'h04);
    exp_q.push_back(32'h08); exp_q.push_back(32'h0C);
    tick(5);

    // ID stall at pc=0x10 for three cycles
    id_allow_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_pc", {32'd0, irom_addr}, 64'h10);
      chk("stall_irom_en", {63'd0, irom_en}, 64'd0);
      chk("stall_valid", {63'd0, if_to_id_valid}, 64'd1);
      tick(1);
    end
    id_allow_in = 1'b1;
    exp_q.push_back(32'h10); exp_q.push_back(32'h14);
    exp_q.push_back(32'h18); exp_q.push_back(32'h1C);
    tick(4);

    // taken branch at pc=0x20 -> 0x40
    chk("br_pc", {32'd0, irom_addr}, 64'h20);
    br_taken = 1'b1; br_target = 32'h40;
    #1;
    chk("br_valid", {63'd0, if_to_id_valid}, 64'd0);
    chk("br_irom_en", {63'd0, irom_en}, 64'd0);
    tick(1);
    br_taken = 1'b0;
    exp_q.push_back(32'h40);
    #1;
    chk("br_next_valid", {63'd0, if_to_id_valid}, 64'd1);
    tick(1);

    // branch while ID stalled at pc=0x44 -> 0x60
    id_allow_in = 1'b0; br_taken = 1'b1; br_target = 32'h60;
    #1;
    chk("brstall_valid", {63'd0, if_to_id_valid}, 64'd0);
    chk("brstall_irom_en", {63'd0, irom_en}, 64'd0);
    tick(1);
    br_taken = 1'b0;
    #1;
    chk("brstall_pc", {32'd0, irom_addr}, 64'h60);
    chk("brstall_next_valid", {63'd0, if_to_id_valid}, 64'd1);
    id_allow_in = 1'b1;
    exp_q.push_back(32'h60);
    tick(1);

    // simultaneous trap and branch at pc=0x64: trap target wins
    trap_redirect = 1'b1; trap_target = 32'h100;
    br_taken = 1'b1; br_target = 32'h80;
    #1;
    chk("trapbr_valid", {63'd0, if_to_id_valid}, 64'd0);
    tick(1);
    trap_redirect = 1'b0; br_taken = 1'b0;
    exp_q.push_back(32'h100);
    tick(1);

    // misaligned branch target at pc=0x104 -> 0x42
    br_taken = 1'b1; br_target = 32'h42;
    tick(1);
    br_taken = 1'b0;
    exp_q.push_back(32'h42);
    #1;
    chk("mis_excp", {63'd0, if_excp}, 64'd1);
    chk("mis_valid", {63'd0, if_to_id_valid}, 64'd1);
    tick(1);
    // fetch continues sequentially at 0x46; trap clears the misalignment
    chk("mis_seq_pc", {32'd0, irom_addr}, 64'h46);
    trap_redirect = 1'b1; trap_target = 32'h200;
    tick(1);
    trap_redirect = 1'b0;
    exp_q.push_back(32'h200);
    #1;
    chk("trap_excp", {63'd0, if_excp}, 64'd0);
    tick(1);

    // steer to 0x58, then asynchronous reset mid-cycle with a branch pending
    br_taken = 1'b1; br_target = 32'h58;
    tick(1);
    chk("pre_rst_pc", {32'd0, irom_addr}, 64'h58);
    br_target = 32'h300;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, if_to_id_valid}, 64'd0);
    chk("async_rst_irom_en", {63'd0, irom_en}, 64'd0);
    chk("async_rst_bus", if_to_id_bus, {32'd4, 32'd0});
    br_taken = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reboot_valid", {63'd0, if_to_id_valid}, 64'd0);
    exp_q.push_back(32'h0);
    tick(2);

    // wrap: branch to 0xFFFF_FFFC from pc=4, then sequential wrap to 0
    chk("prewrap_pc", {32'd0, irom_addr}, 64'h4);
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick(1);
    br_taken = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    #1;
    chk("wrap_pc4", {32'd0, if_to_id_bus[63:32]}, 64'd0);
    tick(2);
    chk("wrap_next_pc", {32'd0, irom_addr}, 64'h4);
    id_allow_in = 1'b0;
    tick(2);

    chk("queue_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
